// File: rtl/ofdm_pkg.sv
// Shared OFDM receive-chain definitions: default widths, 16-QAM Gray level codes,
// demapper FSM state type and tdata field helpers for the default component width.
// Latency: n/a (declarations only).  Backpressure: n/a.
package ofdm_pkg;

  localparam int DEF_W     = 16;    // bits per I/Q component
  localparam int DEF_N_SC  = 8;     // subcarriers per OFDM frame (even)
  localparam int DEF_LEVEL = 4096;  // unit amplitude A

  // Gray-coded decisions for the levels -3A, -A, +A, +3A
  localparam logic [1:0] GRAY_M3 = 2'b00;
  localparam logic [1:0] GRAY_M1 = 2'b01;
  localparam logic [1:0] GRAY_P1 = 2'b11;
  localparam logic [1:0] GRAY_P3 = 2'b10;

  // HI: waiting for the symbol that fills byte[7:4]; LO: waiting for byte[3:0]
  typedef enum logic {
    ST_HI = 1'b0,
    ST_LO = 1'b1
  } demap_state_t;

  // tdata = {I, Q}; I is the real part in the upper half
  function automatic logic [DEF_W-1:0] tdata_i(input logic [2*DEF_W-1:0] td);
    return td[2*DEF_W-1:DEF_W];
  endfunction

  function automatic logic [DEF_W-1:0] tdata_q(input logic [2*DEF_W-1:0] td);
    return td[DEF_W-1:0];
  endfunction

endpackage

// File: rtl/qam16_slicer.sv
// One-axis 16-QAM hard slicer: W-bit two's complement sample -> 2-bit Gray code.
// Latency: combinational.  Backpressure: none (pure function of x).
// Ports: x (signed sample in), code (Gray decision out).
module qam16_slicer
  import ofdm_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int LEVEL = DEF_LEVEL
) (
  input  logic signed [W-1:0] x,
  output logic        [1:0]   code
);

  // Two guard bits so 2A stays representable even when it equals 2^(W-1)
  localparam logic signed [W+1:0] TWO_A = (W+2)'(2 * LEVEL);

  logic signed [W+1:0] xe;
  assign xe = {{2{x[W-1]}}, x};

  // Ties: exact 2A -> +3A, zero -> +A, exact -2A -> -A. Anything beyond the
  // outer thresholds simply lands on the outer decision.
  always_comb begin
    if (xe >= TWO_A)       code = GRAY_P3;
    else if (!x[W-1])      code = GRAY_P1;
    else if (xe >= -TWO_A) code = GRAY_M1;
    else                   code = GRAY_M3;
  end

endmodule

// File: rtl/qam16_demapper.sv
// 16-QAM hard-decision demapper: slices I/Q per beat, packs two nibbles per byte.
// Latency: byte valid the cycle after the accepting edge of its second symbol.
// Backpressure: stalls input only in LO while a stalled byte is pending; 1 symbol/cycle otherwise.
// Ports: aclk/aresetn; s_axis_* sample input ({I,Q}, valid/ready/last);
//        m_data_out/m_dvalid/m_dlast/m_dready byte output; frame_err when QAM_DEMAP_ERR_EN is defined.
// Option QAM_DEMAP_ERR_EN: adds the subcarrier counter and the frame_err length-error pulse.
module qam16_demapper
  import ofdm_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int N_SC  = DEF_N_SC,
  parameter int LEVEL = DEF_LEVEL
) (
  input  logic           aclk,
  input  logic           aresetn,
  input  logic [2*W-1:0] s_axis_tdata,
  input  logic           s_axis_tvalid,
  input  logic           s_axis_tlast,
  output logic           s_axis_tready,
  output logic [7:0]     m_data_out,
  output logic           m_dvalid,
  output logic           m_dlast,
  input  logic           m_dready
`ifdef QAM_DEMAP_ERR_EN
  ,
  output logic           frame_err
`endif
);

  // Frames pack two symbols per byte, so the frame length must be even
  if ((N_SC % 2) != 0 || N_SC < 2) begin : g_bad_n_sc
    $error("qam16_demapper: N_SC must be even and at least 2");
  end

  demap_state_t state;
  logic [3:0]   nib_hi;
  logic [1:0]   code_i;
  logic [1:0]   code_q;
  logic [3:0]   nib;
  logic         accept;

  qam16_slicer #(.W(W), .LEVEL(LEVEL)) u_slice_i (
    .x    (s_axis_tdata[2*W-1:W]),
    .code (code_i)
  );

  qam16_slicer #(.W(W), .LEVEL(LEVEL)) u_slice_q (
    .x    (s_axis_tdata[W-1:0]),
    .code (code_q)
  );

  assign nib = {code_i, code_q};

  // HI never blocks: the first nibble only goes to nib_hi. The odd-frame
  // tail byte also loads from HI, so a sink stalled at that moment loses
  // the pending byte; even-length frames never reach that path.
  assign s_axis_tready = (state == ST_HI) || !m_dvalid || m_dready;
  assign accept        = s_axis_tvalid && s_axis_tready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= ST_HI;
      nib_hi     <= 4'h0;
      m_data_out <= 8'h00;
      m_dvalid   <= 1'b0;
      m_dlast    <= 1'b0;
    end else begin
      // Taken byte retires unless a new one loads on the same edge below
      if (m_dready) m_dvalid <= 1'b0;
      if (accept) begin
        case (state)
          ST_HI: begin
            nib_hi <= nib;
            if (s_axis_tlast) begin
              m_data_out <= {nib, 4'h0};
              m_dvalid   <= 1'b1;
              m_dlast    <= 1'b1;
            end else begin
              state <= ST_LO;
            end
          end
          ST_LO: begin
            m_data_out <= {nib_hi, nib};
            m_dvalid   <= 1'b1;
            m_dlast    <= s_axis_tlast;
            state      <= ST_HI;
          end
          default: state <= ST_HI;
        endcase
      end
    end
  end

`ifdef QAM_DEMAP_ERR_EN
  localparam int CW = (N_SC > 2) ? $clog2(N_SC) : 1;
  localparam logic [CW-1:0] SC_LAST = CW'(N_SC - 1);

  logic [CW-1:0] sym_cnt;

  // Counter tracks position in the frame; errors are flagged but the data
  // path keeps packing exactly as tlast dictates.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sym_cnt   <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (accept) begin
        if (s_axis_tlast || sym_cnt == SC_LAST) sym_cnt <= '0;
        else                                    sym_cnt <= sym_cnt + 1'b1;
        frame_err <= (s_axis_tlast != (sym_cnt == SC_LAST));
      end
    end
  end
`endif

endmodule
